data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Parametrised data memory for the CPU's load/store stage. It replaces the fixed 16-word, level-sensitive memory with a clocked, request/response block. The block supports byte, halfword and word accesses with sign or zero extension, and flags misaligned accesses. Access latency is configurable, and the array self-clears to zero after every reset.

## Interface
Parameters:
- DEPTH, 16, number of 32-bit words; power of two, ≥2. Byte-address width AW = log2(DEPTH)+2.
- WAIT_STATES, 0, extra cycles between request acceptance and array access; range 0..15.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block accepts a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  AW  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer takes the response.
- resp_rdata  output  32  load result, extended to 32 bits.
- resp_error  output  1  request was misaligned or illegal; no array effect.

## Operation
- FSM states: CLEAR, IDLE, WAIT, RESP.
- Reset: at any edge with rst=1, go to CLEAR with clear index 0.
  - Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0, wait counter 0.
  - rst overrides every state. A store not yet committed is dropped, and a pending response is discarded.
- CLEAR: write 0 to mem[idx] and increment idx each cycle. After the write of word DEPTH-1, go to IDLE.
- IDLE:
  - req_ready=1 only in IDLE.
  - Accept on req_valid&&req_ready; latch write, size, signed, addr and wdata.
  - If WAIT_STATES=0, perform the access on the accepting edge and go to RESP.
  - Otherwise go to WAIT with counter=WAIT_STATES.
- WAIT: decrement the counter each edge. On the edge where the counter is 1, perform the access and go to RESP.
- Access, little-endian. Word index = addr[AW-1:2]; byte lane k = addr[1:0], occupying bits [8k+7:8k].
  - Error conditions: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]≠0.
  - On error: no write, rdata=0, error=1.
  - Byte store: write only lane k with wdata[7:0]. Other lanes are unchanged.
  - Half store: write lanes {2·addr[1], 2·addr[1]+1} with wdata[15:0].
  - Word store: write the full word.
  - Store response: rdata=0, error=0.
  - Load: extract the lane(s) and extend per req_signed to 32 bits. Word loads ignore req_signed.
- RESP: resp_valid=1 with rdata/error stable. On an edge with resp_ready=1, go to IDLE and clear resp_valid. resp_valid is held indefinitely while resp_ready=0.
- Only one request is outstanding at a time. Request inputs are ignored outside IDLE.

## Timing
- After rst deasserts, req_ready rises DEPTH cycles later (CLEAR spans DEPTH edges).
- Access commits at acceptance edge E0 + WAIT_STATES edges.
- resp_valid is first high in the cycle after the commit edge.
- Minimum request spacing is WAIT_STATES+2 cycles (accept, respond, return to IDLE).
- A load returns array contents as of before the commit edge. Stores become visible to the next request.
- Outputs are registered. No combinational path from any input to any output.

## Test plan
- Reset/clear, DEPTH=16:
  - Pulse rst, then hold req_valid=1. req_ready must stay 0 for 16 cycles after rst falls.
  - A word load of addr 0x3C must then return 0x00000000, error=0.
- Word round trip, WAIT_STATES=0:
  - Store 0xDEADBEEF to 0x08, then load 0x08. The load returns 0xDEADBEEF.
  - resp_valid is high one cycle after each acceptance.
- Sub-word, after the round trip above:
  - Byte store 0x7F to 0x09, then word load of 0x08 → 0xDEAD7FEF.
  - Signed byte load of 0x0B → 0xFFFFFFDE; unsigned → 0x000000DE.
  - Signed half load of 0x0A → 0xFFFFDEAD.
- Misalignment:
  - Word store 0x12345678 to 0x0A → resp_error=1, rdata=0. A following word load of 0x08 still returns 0xDEAD7FEF.
  - Half load of 0x05 → error=1.
  - size=11 → error=1.
- Latency/backpressure, WAIT_STATES=3:
  - Load accepted at edge E0 → resp_valid first high after E3.
  - Hold resp_ready=0 for 5 cycles: resp_valid and rdata stay stable and req_ready stays 0.
  - Raise resp_ready: req_ready=1 in the next cycle.
- Reset mid-operation:
  - Store accepted with WAIT_STATES=3, then rst asserted before commit.
  - resp_valid must never assert. After re-clear, a load of that address returns 0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Clocked request/response data memory for the load/store stage.
// Supports byte, halfword and word accesses with sign/zero extension on loads.
// Misaligned or illegal-size requests get an error response and leave the array alone.
// After every reset the array is walked and cleared to zero before requests are accepted.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, >= 2)
//   WAIT_STATES  extra cycles between acceptance and array access (0..15)
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   req_*        request channel (valid/ready handshake, write, size, signed, addr, wdata)
//   resp_*       response channel (valid/ready handshake, rdata, error)
module data_mem_ctrl #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  localparam int AW         = $clog2(DEPTH) + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_error
);

  localparam int IW = AW - 2;

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

  state_t        state, next_state;
  logic [IW-1:0] clr_idx;
  logic [3:0]    wait_cnt;

  logic          lat_write;
  logic [1:0]    lat_size;
  logic          lat_signed;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          do_access;

  logic          acc_write;
  logic [1:0]    acc_size;
  logic          acc_signed;
  logic [AW-1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [IW-1:0] acc_idx;
  logic [1:0]    acc_lane;
  logic          acc_err;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  // req_ready is registered and high exactly in IDLE, so it doubles as the accept qualifier.
  assign accept = req_valid && req_ready;

  // With no wait states the access happens on the accepting edge using the live request;
  // otherwise it happens on the last WAIT edge using the latched request.
  assign do_access = ((state == IDLE) && accept && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (wait_cnt == 4'd1));

  // Access operand selection, alignment check, load extraction and store lane enables.
  always_comb begin
    acc_write  = lat_write;
    acc_size   = lat_size;
    acc_signed = lat_signed;
    acc_addr   = lat_addr;
    acc_wdata  = lat_wdata;
    if (state == IDLE) begin
      acc_write  = req_write;
      acc_size   = req_size;
      acc_signed = req_signed;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
    end

    acc_idx  = acc_addr[AW-1:2];
    acc_lane = acc_addr[1:0];

    case (acc_size)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = acc_addr[0];
      2'b10:   acc_err = |acc_addr[1:0];
      default: acc_err = 1'b1;
    endcase

    rd_word = mem[acc_idx];
    rd_byte = rd_word[{acc_lane, 3'b000} +: 8];
    rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

    case (acc_size)
      2'b00:   load_val = {{24{acc_signed & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{acc_signed & rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase

    case (acc_size)
      2'b00: begin
        wr_be   = 4'b0001 << acc_lane;
        wr_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = acc_wdata;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      CLEAR: if (clr_idx == IW'(DEPTH - 1)) next_state = IDLE;
      IDLE:  if (accept) next_state = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:  if (wait_cnt == 4'd1) next_state = RESP;
      RESP:  if (resp_ready) next_state = IDLE;
      default: next_state = CLEAR;
    endcase
  end

  // Registered handshake outputs, clear index, wait counter, request latch and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      clr_idx    <= '0;
      wait_cnt   <= '0;
      lat_write  <= 1'b0;
      lat_size   <= '0;
      lat_signed <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      req_ready  <= (next_state == IDLE);
      resp_valid <= (next_state == RESP);
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
      if ((state == IDLE) && accept) begin
        lat_write  <= req_write;
        lat_size   <= req_size;
        lat_signed <= req_signed;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        wait_cnt   <= 4'(WAIT_STATES);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      // Stores and errors both return zero data.
      if (do_access) begin
        resp_error <= acc_err;
        resp_rdata <= (acc_err || acc_write) ? 32'h0 : load_val;
      end
    end
  end

  // Array writes: the clear walk, then lane-enabled stores. Reset suppresses any pending commit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (do_access && acc_write && !acc_err) begin
        for (int k = 0; k < 4; k++) begin
          if (wr_be[k]) mem[acc_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
// Directed self-checking bench for data_mem_ctrl. Instance A has no wait states,
// instance B has three. Request fields and resp_ready are shared; each instance has
// its own rst and req_valid so only one is ever driven at a time.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        req_valid_a, req_valid_b;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;
  logic        req_ready_a, req_ready_b;
  logic        resp_valid_a, resp_valid_b;
  logic [31:0] resp_rdata_a, resp_rdata_b;
  logic        resp_error_a, resp_error_b;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n;
  logic        seen;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH(16), .WAIT_STATES(0)) dut_a (
    .clk(clk), .rst(rst_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata_a), .resp_error(resp_error_a)
  );

  data_mem_ctrl #(.DEPTH(16), .WAIT_STATES(3)) dut_b (
    .clk(clk), .rst(rst_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata_b), .resp_error(resp_error_b)
  );

  // One comparison: count it, and on mismatch count the failure and report it.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Full transaction on instance sel (0 = A, 1 = B). After acceptance the request fields
  // are scrambled so the DUT must rely on its own latch. hold > 0 keeps resp_ready low for
  // that many cycles and checks the response stays put.
  task automatic applyStimulus(input bit sel, input logic wr, input logic [1:0] size,
                               input logic sgn, input logic [5:0] addr, input logic [31:0] wdata,
                               input int hold, output logic [31:0] rdata, output logic err,
                               output int cyc);
    int w;
    req_write  = wr;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = 1'b0;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    w = 0;
    while (!(sel ? req_ready_b : req_ready_a) && w < 100) begin
      @(posedge clk); #1; w++;
    end
    checkOutput("accept_in_time", 32'(w < 100), 32'd1);
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_write   = ~wr;
    req_size    = ~size;
    req_signed  = ~sgn;
    req_addr    = ~addr;
    req_wdata   = ~wdata;
    cyc = 0;
    while (!(sel ? resp_valid_b : resp_valid_a) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    rdata = sel ? resp_rdata_b : resp_rdata_a;
    err   = sel ? resp_error_b : resp_error_a;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(sel ? resp_valid_b : resp_valid_a), 32'd1);
      checkOutput("hold_rdata", sel ? resp_rdata_b : resp_rdata_a, rdata);
      checkOutput("hold_req_ready", 32'(sel ? req_ready_b : req_ready_a), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    if (hold > 0) begin
      checkOutput("ready_after_release", 32'(sel ? req_ready_b : req_ready_a), 32'd1);
      checkOutput("valid_after_release", 32'(sel ? resp_valid_b : resp_valid_a), 32'd0);
    end
  endtask

  // Transaction plus checks of data, error and response latency.
  task automatic runAndCheck(input string tag, input bit sel, input logic wr,
                             input logic [1:0] size, input logic sgn, input logic [5:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rdata,
                             input logic exp_err);
    logic [31:0] r;
    logic        e;
    int          c;
    applyStimulus(sel, wr, size, sgn, addr, wdata, 0, r, e, c);
    checkOutput({tag, "_rdata"}, r, exp_rdata);
    checkOutput({tag, "_error"}, 32'(e), 32'(exp_err));
    checkOutput({tag, "_latency"}, 32'(c), sel ? 32'd3 : 32'd0);
  endtask

  initial begin
    rst_a       = 1'b1;
    rst_b       = 1'b1;
    req_valid_a = 1'b1;
    req_valid_b = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'b10;
    req_signed  = 1'b0;
    req_addr    = 6'h3C;
    req_wdata   = 32'h0;
    resp_ready  = 1'b0;

    // Reset and clear: req_ready held low for 16 cycles with req_valid asserted.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_resp_valid", 32'(resp_valid_a), 32'd0);
    checkOutput("reset_rdata", resp_rdata_a, 32'h0);
    checkOutput("reset_error", 32'(resp_error_a), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkOutput("clear_ready_low", 32'(req_ready_a), 32'd0);
      @(posedge clk); #1;
    end
    checkOutput("ready_after_clear", 32'(req_ready_a), 32'd1);
    runAndCheck("load_3c_cleared", 0, 1'b0, 2'b10, 1'b0, 6'h3C, 32'h0, 32'h0, 1'b0);

    // Word round trip.
    runAndCheck("store_w_08", 0, 1'b1, 2'b10, 1'b0, 6'h08, 32'hDEADBEEF, 32'h0, 1'b0);
    runAndCheck("load_w_08", 0, 1'b0, 2'b10, 1'b0, 6'h08, 32'h0, 32'hDEADBEEF, 1'b0);

    // Sub-word stores and loads; upper wdata bits must not leak into other lanes.
    runAndCheck("store_b_09", 0, 1'b1, 2'b00, 1'b0, 6'h09, 32'hAAAAAA7F, 32'h0, 1'b0);
    runAndCheck("load_w_08_b", 0, 1'b0, 2'b10, 1'b0, 6'h08, 32'h0, 32'hDEAD7FEF, 1'b0);
    runAndCheck("load_sb_0b", 0, 1'b0, 2'b00, 1'b1, 6'h0B, 32'h0, 32'hFFFFFFDE, 1'b0);
    runAndCheck("load_ub_0b", 0, 1'b0, 2'b00, 1'b0, 6'h0B, 32'h0, 32'h000000DE, 1'b0);
    runAndCheck("load_sh_0a", 0, 1'b0, 2'b01, 1'b1, 6'h0A, 32'h0, 32'hFFFFDEAD, 1'b0);
    runAndCheck("load_uh_08", 0, 1'b0, 2'b01, 1'b0, 6'h08, 32'h0, 32'h00007FEF, 1'b0);
    runAndCheck("load_sb_09", 0, 1'b0, 2'b00, 1'b1, 6'h09, 32'h0, 32'h0000007F, 1'b0);
    runAndCheck("store_h_0e", 0, 1'b1, 2'b01, 1'b0, 6'h0E, 32'hAAAA8001, 32'h0, 1'b0);
    runAndCheck("load_w_0c", 0, 1'b0, 2'b10, 1'b0, 6'h0C, 32'h0, 32'h80010000, 1'b0);
    runAndCheck("load_sh_0e", 0, 1'b0, 2'b01, 1'b1, 6'h0E, 32'h0, 32'hFFFF8001, 1'b0);

    // Misaligned and illegal requests.
    runAndCheck("store_w_0a_mis", 0, 1'b1, 2'b10, 1'b0, 6'h0A, 32'h12345678, 32'h0, 1'b1);
    runAndCheck("load_w_08_after", 0, 1'b0, 2'b10, 1'b0, 6'h08, 32'h0, 32'hDEAD7FEF, 1'b0);
    runAndCheck("load_h_05_mis", 0, 1'b0, 2'b01, 1'b0, 6'h05, 32'h0, 32'h0, 1'b1);
    runAndCheck("load_size11", 0, 1'b0, 2'b11, 1'b0, 6'h08, 32'h0, 32'h0, 1'b1);
    runAndCheck("store_size11", 0, 1'b1, 2'b11, 1'b0, 6'h0C, 32'h11111111, 32'h0, 1'b1);
    runAndCheck("load_w_0c_after", 0, 1'b0, 2'b10, 1'b0, 6'h0C, 32'h0, 32'h80010000, 1'b0);

    // Wait states and backpressure on instance B.
    runAndCheck("b_store_w_10", 1, 1'b1, 2'b10, 1'b0, 6'h10, 32'hCAFEF00D, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0, 5, rd, er, lat);
    checkOutput("b_bp_rdata", rd, 32'hCAFEF00D);
    checkOutput("b_bp_error", 32'(er), 32'd0);
    checkOutput("b_bp_latency", 32'(lat), 32'd3);
    runAndCheck("b_load_ub_13", 1, 1'b0, 2'b00, 1'b0, 6'h13, 32'h0, 32'h000000CA, 1'b0);

    // Reset between acceptance and commit: store dropped, no response, array re-cleared.
    req_write   = 1'b1;
    req_size    = 2'b10;
    req_signed  = 1'b0;
    req_addr    = 6'h14;
    req_wdata   = 32'h55AA55AA;
    req_valid_b = 1'b1;
    n = 0;
    while (!req_ready_b && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("b_midrst_accept", 32'(n < 100), 32'd1);
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    seen = resp_valid_b;
    @(posedge clk); #1;
    seen = seen | resp_valid_b;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    n = 0;
    while (!req_ready_b && n < 100) begin
      seen = seen | resp_valid_b;
      @(posedge clk); #1; n++;
    end
    seen = seen | resp_valid_b;
    checkOutput("b_midrst_no_resp", 32'(seen), 32'd0);
    checkOutput("b_reclear_cycles", 32'(n), 32'd16);
    runAndCheck("b_load_14_cleared", 1, 1'b0, 2'b10, 1'b0, 6'h14, 32'h0, 32'h0, 1'b0);
    runAndCheck("b_load_10_cleared", 1, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
